// File: rtl/axil_pkg.sv
// Shared widths, response codes, address window and FSM states
// for the AXI4-Lite forwarding stage.
package axil_pkg;

  localparam int addrWidth = 32;
  localparam int dataWidth = 32;
  localparam int strbWidth = dataWidth / 8;

  localparam logic [addrWidth-1:0] ADDR_BASE = 'h0;
  localparam logic [addrWidth-1:0] ADDR_SIZE = 'h1000;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ISSUE,
    W_WAIT,
    W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_WAIT,
    R_RESP
  } rstate_t;

  // Unsigned wrap makes one compare cover both window edges
  function automatic logic addr_ok(
    input logic [addrWidth-1:0] a
  );
    return (a - ADDR_BASE) < ADDR_SIZE;
  endfunction

endpackage

// File: rtl/axi4_Lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
// Widths come from axil_pkg.
interface axi4_Lite;
  import axil_pkg::*;

  logic [addrWidth-1:0] awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [dataWidth-1:0] wdata;
  logic [strbWidth-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [addrWidth-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [dataWidth-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport axiSlave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport axiMaster (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

endinterface

// File: rtl/axil_hold_reg.sv
// Valid flag plus payload register; load sets, clear drops valid.
// Clear wins over load; payload only changes on load.
module axil_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         vld_o,
  output logic [W-1:0] q_o
);

  logic         vld_q;
  logic [W-1:0] q_q;

  // Track the valid flag and capture payload on load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      q_q   <= '0;
    end else begin
      if (clr_i)     vld_q <= 1'b0;
      else if (ld_i) vld_q <= 1'b1;
      if (ld_i)      q_q   <= d_i;
    end
  end

  assign vld_o = vld_q;
  assign q_o   = q_q;

endmodule

// File: rtl/axi_lite_structure.sv
// AXI4-Lite slave-to-master forwarding stage, one wr + one rd in flight.
// Define AXIL_STRUCT_ADDR_CHECK_EN to answer out-of-window addrs with DECERR.
module axi_lite_structure
  import axil_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  axi4_Lite.axiSlave           s,
  output logic [addrWidth-1:0] awaddrM,
  output logic [2:0]           awprotM,
  output logic                 awvalidM,
  input  logic                 awreadyM,
  output logic [dataWidth-1:0] wdataM,
  output logic [strbWidth-1:0] wstrbM,
  output logic                 wvalidM,
  input  logic                 wreadyM,
  input  logic                 bvalidM,
  input  logic [1:0]           brespM,
  output logic                 breadyM,
  output logic [addrWidth-1:0] araddrM,
  output logic [2:0]           arprotM,
  output logic                 arvalidM,
  input  logic                 arreadyM,
  input  logic                 rvalidM,
  input  logic [dataWidth-1:0] rdataM,
  input  logic [1:0]           rrespM,
  output logic                 rreadyM
);

  localparam int AW = addrWidth + 3;
  localparam int WW = dataWidth + strbWidth;

  wstate_t wr_q, wr_d;
  rstate_t rd_q, rd_d;

  logic awready_q, awready_d;
  logic wready_q, wready_d;
  logic awvalidM_q, awvalidM_d;
  logic wvalidM_q, wvalidM_d;
  logic breadyM_q, breadyM_d;
  logic bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic arready_q, arready_d;
  logic rreadyM_q, rreadyM_d;
  logic rvalid_q, rvalid_d;
  logic [1:0] rresp_q, rresp_d;
  logic [dataWidth-1:0] rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs;
  logic aw_vld, w_vld, ar_vld;
  logic aw_vn, w_vn;
  logic wr_clr, ar_clr, ar_ld;
  logic wr_dec, rd_dec;
  logic [AW-1:0] aw_q, ar_q;
  logic [WW-1:0] w_q;

  assign aw_hs  = s.awvalid && awready_q;
  assign w_hs   = s.wvalid && wready_q;
  assign ar_hs  = s.arvalid && arready_q;
  assign wr_clr = (wr_q == W_RESP) && s.bready;
  assign aw_vn  = !wr_clr && (aw_vld || aw_hs);
  assign w_vn   = !wr_clr && (w_vld || w_hs);
  assign ar_ld  = ar_hs && (rd_d == R_ISSUE);
  assign ar_clr = ar_vld && arreadyM;

`ifdef AXIL_STRUCT_ADDR_CHECK_EN
  logic [addrWidth-1:0] aw_addr_n;
  assign aw_addr_n = aw_hs ? s.awaddr
                           : aw_q[addrWidth-1:0];
`endif

  axil_hold_reg #(.W(AW)) u_aw (
    .clk   (clk),
    .rst   (rst),
    .ld_i  (aw_hs),
    .clr_i (wr_clr),
    .d_i   ({s.awprot, s.awaddr}),
    .vld_o (aw_vld),
    .q_o   (aw_q)
  );

  axil_hold_reg #(.W(WW)) u_w (
    .clk   (clk),
    .rst   (rst),
    .ld_i  (w_hs),
    .clr_i (wr_clr),
    .d_i   ({s.wstrb, s.wdata}),
    .vld_o (w_vld),
    .q_o   (w_q)
  );

  // AR holder valid doubles as the M-side arvalid
  axil_hold_reg #(.W(AW)) u_ar (
    .clk   (clk),
    .rst   (rst),
    .ld_i  (ar_ld),
    .clr_i (ar_clr),
    .d_i   ({s.arprot, s.araddr}),
    .vld_o (ar_vld),
    .q_o   (ar_q)
  );

  // State registers for both FSMs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= W_IDLE;
      rd_q <= R_IDLE;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Write next-state
  always_comb begin
    wr_d = wr_q;
    unique case (wr_q)
      W_IDLE: if (aw_vn && w_vn) begin
        wr_d = W_ISSUE;
`ifdef AXIL_STRUCT_ADDR_CHECK_EN
        if (!addr_ok(aw_addr_n)) wr_d = W_RESP;
`endif
      end
      W_ISSUE:
        if ((!awvalidM_q || awreadyM) &&
            (!wvalidM_q || wreadyM))
          wr_d = W_WAIT;
      W_WAIT: if (bvalidM) wr_d = W_RESP;
      W_RESP: if (s.bready) wr_d = W_IDLE;
      default: wr_d = W_IDLE;
    endcase
  end

  // Read next-state
  always_comb begin
    rd_d = rd_q;
    unique case (rd_q)
      R_IDLE: if (ar_hs) begin
        rd_d = R_ISSUE;
`ifdef AXIL_STRUCT_ADDR_CHECK_EN
        if (!addr_ok(s.araddr)) rd_d = R_RESP;
`endif
      end
      R_ISSUE: if (ar_vld && arreadyM) rd_d = R_WAIT;
      R_WAIT:  if (rvalidM) rd_d = R_RESP;
      R_RESP:  if (s.rready) rd_d = R_IDLE;
      default: rd_d = R_IDLE;
    endcase
  end

  assign wr_dec = (wr_q == W_IDLE) && (wr_d == W_RESP);
  assign rd_dec = (rd_q == R_IDLE) && (rd_d == R_RESP);

  // Write outputs, computed from the upcoming state
  always_comb begin
    awready_d  = (wr_d == W_IDLE) && !aw_vn;
    wready_d   = (wr_d == W_IDLE) && !w_vn;
    awvalidM_d = 1'b0;
    wvalidM_d  = 1'b0;
    if (wr_d == W_ISSUE) begin
      if (wr_q == W_IDLE) begin
        awvalidM_d = 1'b1;
        wvalidM_d  = 1'b1;
      end else begin
        awvalidM_d = awvalidM_q && !awreadyM;
        wvalidM_d  = wvalidM_q && !wreadyM;
      end
    end
    breadyM_d = (wr_d == W_WAIT);
    bvalid_d  = (wr_d == W_RESP);
    bresp_d   = bresp_q;
    if (wr_dec)
      bresp_d = DECERR;
    else if (wr_q == W_WAIT && bvalidM)
      bresp_d = brespM;
  end

  // Read outputs, computed from the upcoming state
  always_comb begin
    arready_d = (rd_d == R_IDLE);
    rreadyM_d = (rd_d == R_WAIT);
    rvalid_d  = (rd_d == R_RESP);
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (rd_dec) begin
      rresp_d = DECERR;
      rdata_d = '0;
    end else if (rd_q == R_WAIT && rvalidM) begin
      rresp_d = rrespM;
      rdata_d = rdataM;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      awvalidM_q <= 1'b0;
      wvalidM_q  <= 1'b0;
      breadyM_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      arready_q  <= 1'b0;
      rreadyM_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
    end else begin
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      awvalidM_q <= awvalidM_d;
      wvalidM_q  <= wvalidM_d;
      breadyM_q  <= breadyM_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rreadyM_q  <= rreadyM_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rresp   = rresp_q;
  assign s.rdata   = rdata_q;

  assign awaddrM  = aw_q[addrWidth-1:0];
  assign awprotM  = aw_q[addrWidth+:3];
  assign awvalidM = awvalidM_q;
  assign wdataM   = w_q[dataWidth-1:0];
  assign wstrbM   = w_q[dataWidth+:strbWidth];
  assign wvalidM  = wvalidM_q;
  assign breadyM  = breadyM_q;
  assign araddrM  = ar_q[addrWidth-1:0];
  assign arprotM  = ar_q[addrWidth+:3];
  assign arvalidM = ar_vld;
  assign rreadyM  = rreadyM_q;

endmodule

// File: tb/tb_axi_lite_structure.sv
// Directed bench for axi_lite_structure.
// Out-of-window read step runs when AXIL_STRUCT_ADDR_CHECK_EN is defined.
module tb_axi_lite_structure;
  import axil_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [addrWidth-1:0] awaddrM, araddrM;
  logic [2:0]           awprotM, arprotM;
  logic                 awvalidM, wvalidM, arvalidM;
  logic                 breadyM, rreadyM;
  logic [dataWidth-1:0] wdataM;
  logic [strbWidth-1:0] wstrbM;
  logic                 awreadyM = 1'b0;
  logic                 wreadyM  = 1'b0;
  logic                 bvalidM  = 1'b0;
  logic [1:0]           brespM   = 2'b00;
  logic                 arreadyM = 1'b0;
  logic                 rvalidM  = 1'b0;
  logic [dataWidth-1:0] rdataM   = '0;
  logic [1:0]           rrespM   = 2'b00;

  int ncmp = 0;
  int nerr = 0;

  axi4_Lite bus ();

  axi_lite_structure dut (
    .clk      (clk),
    .rst      (rst),
    .s        (bus),
    .awaddrM  (awaddrM),
    .awprotM  (awprotM),
    .awvalidM (awvalidM),
    .awreadyM (awreadyM),
    .wdataM   (wdataM),
    .wstrbM   (wstrbM),
    .wvalidM  (wvalidM),
    .wreadyM  (wreadyM),
    .bvalidM  (bvalidM),
    .brespM   (brespM),
    .breadyM  (breadyM),
    .araddrM  (araddrM),
    .arprotM  (arprotM),
    .arvalidM (arvalidM),
    .arreadyM (arreadyM),
    .rvalidM  (rvalidM),
    .rdataM   (rdataM),
    .rrespM   (rrespM),
    .rreadyM  (rreadyM)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    bus.awaddr  = '0;
    bus.awprot  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arprot  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    rst = 1'b1;
    tick();
    chk("rel_awready", bus.awready, 1'b1);
    chk("rel_wready", bus.wready, 1'b1);
    chk("rel_arready", bus.arready, 1'b1);

    // reset in the middle of a write
    bus.awaddr  = 32'h44;
    bus.wdata   = 32'h11;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    tick();
    chk("mid_awvalidM", awvalidM, 1'b1);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_awvalidM", awvalidM, 1'b0);
    chk("abort_wvalidM", wvalidM, 1'b0);
    chk("abort_awaddrM", awaddrM, 32'h0);
    chk("abort_awready", bus.awready, 1'b0);
    #2;
    rst = 1'b1;
    tick();
    chk("rel2_awready", bus.awready, 1'b1);
    chk("rel2_awvalidM", awvalidM, 1'b0);

    // write, AW and W together
    bus.awaddr  = 32'h10;
    bus.awprot  = 3'b000;
    bus.wdata   = 32'hDEADBEEF;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    chk("w1_awvalidM", awvalidM, 1'b1);
    chk("w1_wvalidM", wvalidM, 1'b1);
    chk("w1_awaddrM", awaddrM, 32'h10);
    chk("w1_wdataM", wdataM, 32'hDEADBEEF);
    chk("w1_wstrbM", wstrbM, 4'hF);
    chk("w1_awready", bus.awready, 1'b0);
    awreadyM = 1'b1;
    wreadyM  = 1'b1;
    tick();
    awreadyM = 1'b0;
    wreadyM  = 1'b0;
    chk("w1_awvalidM_off", awvalidM, 1'b0);
    chk("w1_breadyM", breadyM, 1'b1);
    bvalidM = 1'b1;
    brespM  = 2'b00;
    tick();
    bvalidM = 1'b0;
    chk("w1_bvalid", bus.bvalid, 1'b1);
    chk("w1_bresp", bus.bresp, 2'b00);
    chk("w1_breadyM_off", breadyM, 1'b0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("w1_bvalid_off", bus.bvalid, 1'b0);
    chk("w1_awready_back", bus.awready, 1'b1);

    // write, W two cycles ahead of AW, slow awreadyM
    bus.wdata  = 32'hA5A5A5A5;
    bus.wstrb  = 4'h3;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    chk("w2_wready", bus.wready, 1'b0);
    chk("w2_awready", bus.awready, 1'b1);
    chk("w2_wvalidM_early", wvalidM, 1'b0);
    tick();
    chk("w2_awvalidM_early", awvalidM, 1'b0);
    bus.awaddr  = 32'h80;
    bus.awprot  = 3'b010;
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    chk("w2_awvalidM", awvalidM, 1'b1);
    chk("w2_wvalidM", wvalidM, 1'b1);
    chk("w2_awaddrM", awaddrM, 32'h80);
    chk("w2_awprotM", awprotM, 3'b010);
    chk("w2_wdataM", wdataM, 32'hA5A5A5A5);
    chk("w2_wstrbM", wstrbM, 4'h3);
    wreadyM = 1'b1;
    tick();
    wreadyM = 1'b0;
    chk("w2_wvalidM_done", wvalidM, 1'b0);
    chk("w2_awvalidM_hold1", awvalidM, 1'b1);
    tick();
    chk("w2_awvalidM_hold2", awvalidM, 1'b1);
    chk("w2_awaddrM_stable", awaddrM, 32'h80);
    awreadyM = 1'b1;
    tick();
    awreadyM = 1'b0;
    chk("w2_awvalidM_done", awvalidM, 1'b0);
    chk("w2_breadyM", breadyM, 1'b1);
    bvalidM = 1'b1;
    brespM  = 2'b10;
    tick();
    bvalidM = 1'b0;
    chk("w2_bvalid", bus.bvalid, 1'b1);
    chk("w2_bresp", bus.bresp, 2'b10);
    chk("w2_no_reissue", awvalidM, 1'b0);
    tick();
    tick();
    chk("w2_bvalid_hold", bus.bvalid, 1'b1);
    chk("w2_wready_busy", bus.wready, 1'b0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("w2_bvalid_off", bus.bvalid, 1'b0);
    chk("w2_wready_back", bus.wready, 1'b1);

    // read with SLVERR passthrough
    bus.araddr  = 32'h20;
    bus.arprot  = 3'b001;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    chk("r1_arvalidM", arvalidM, 1'b1);
    chk("r1_araddrM", araddrM, 32'h20);
    chk("r1_arprotM", arprotM, 3'b001);
    chk("r1_arready", bus.arready, 1'b0);
    arreadyM = 1'b1;
    tick();
    arreadyM = 1'b0;
    chk("r1_arvalidM_off", arvalidM, 1'b0);
    chk("r1_rreadyM", rreadyM, 1'b1);
    rvalidM = 1'b1;
    rdataM  = 32'h12345678;
    rrespM  = 2'b10;
    tick();
    rvalidM = 1'b0;
    chk("r1_rvalid", bus.rvalid, 1'b1);
    chk("r1_rdata", bus.rdata, 32'h12345678);
    chk("r1_rresp", bus.rresp, 2'b10);
    tick();
    chk("r1_rvalid_hold", bus.rvalid, 1'b1);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("r1_rvalid_off", bus.rvalid, 1'b0);
    chk("r1_arready_back", bus.arready, 1'b1);

    // overlapping write and read, rready held low
    bus.awaddr  = 32'h30;
    bus.awprot  = 3'b000;
    bus.wdata   = 32'h0BADF00D;
    bus.wstrb   = 4'hF;
    bus.araddr  = 32'h34;
    bus.arprot  = 3'b000;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.arvalid = 1'b1;
    awreadyM = 1'b1;
    wreadyM  = 1'b1;
    arreadyM = 1'b1;
    bvalidM  = 1'b1;
    brespM   = 2'b11;
    rvalidM  = 1'b1;
    rdataM   = 32'hCAFEF00D;
    rrespM   = 2'b00;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    chk("ov_awvalidM", awvalidM, 1'b1);
    chk("ov_arvalidM", arvalidM, 1'b1);
    chk("ov_araddrM", araddrM, 32'h34);
    tick();
    chk("ov_breadyM", breadyM, 1'b1);
    chk("ov_rreadyM", rreadyM, 1'b1);
    tick();
    awreadyM = 1'b0;
    wreadyM  = 1'b0;
    arreadyM = 1'b0;
    bvalidM  = 1'b0;
    rvalidM  = 1'b0;
    chk("ov_bvalid", bus.bvalid, 1'b1);
    chk("ov_bresp", bus.bresp, 2'b11);
    chk("ov_rvalid", bus.rvalid, 1'b1);
    chk("ov_rdata", bus.rdata, 32'hCAFEF00D);
    chk("ov_rresp", bus.rresp, 2'b00);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("ov_bvalid_off", bus.bvalid, 1'b0);
    chk("ov_awready_back", bus.awready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("ov_arready_low", bus.arready, 1'b0);
      chk("ov_rvalid_hold", bus.rvalid, 1'b1);
      tick();
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("ov_rvalid_off", bus.rvalid, 1'b0);
    chk("ov_arready_back", bus.arready, 1'b1);

`ifdef AXIL_STRUCT_ADDR_CHECK_EN
    // out-of-window read answered locally
    rvalidM = 1'b1;
    rdataM  = 32'hFFFFFFFF;
    rrespM  = 2'b00;
    bus.araddr  = 32'h2000_0000;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    chk("dec_arvalidM", arvalidM, 1'b0);
    chk("dec_rvalid", bus.rvalid, 1'b1);
    chk("dec_rresp", bus.rresp, 2'b11);
    chk("dec_rdata", bus.rdata, 32'h0);
    rvalidM = 1'b0;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("dec_rvalid_off", bus.rvalid, 1'b0);
    chk("dec_arvalidM_never", arvalidM, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/axi_lite_structure.md
# axi_lite_structure

AXI4-Lite slave-to-master forwarding stage. It sits between an upstream AXI4-Lite master and the downstream fabric side of the APB/AXI4-Lite bridge. The stage registers each write and read transaction and re-issues it on the M-side port. It returns the downstream response upstream, with at most one write and one read outstanding at a time.

## Interface
Parameters, taken from the shared package:
- addrWidth, default 32: address width, both sides.
- dataWidth, default 32: data width, both sides; a multiple of 8.

Ports. The S side is the `axi4_Lite` interface, modport `axiSlave`; it is listed here per channel.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- S AW  in awaddr[addrWidth], awprot[3], awvalid; out awready.
- S W  in wdata[dataWidth], wstrb[dataWidth/8], wvalid; out wready.
- S B  out bresp[2], bvalid; in bready.
- S AR  in araddr[addrWidth], arprot[3], arvalid; out arready.
- S R  out rdata[dataWidth], rresp[2], rvalid; in rready.
- awaddrM/awprotM/awvalidM  out  addrWidth/3/1  M write address; awreadyM in 1.
- wdataM/wstrbM/wvalidM  out  dataWidth/(dataWidth/8)/1  M write data; wreadyM in 1.
- bvalidM/brespM  in  1/2  M write response; breadyM out 1.
- araddrM/arprotM/arvalidM  out  addrWidth/3/1  M read address; arreadyM in 1.
- rvalidM/rdataM/rrespM  in  1/dataWidth/2  M read data; rreadyM out 1.

## Operation
- All outputs are registered.
- Every output resets to 0 while rst=0; both FSMs reset to IDLE.

Write FSM: W_IDLE, W_ISSUE, W_WAIT, W_RESP.
- W_IDLE:
  - awready=1 until AW is captured; wready=1 until W is captured.
  - AW and W may arrive in the same cycle or in either order.
  - Once both are held, go to W_ISSUE.
- W_ISSUE:
  - awvalidM and wvalidM are asserted with the held values.
  - Each valid drops independently after its M ready handshake.
  - When both have completed, go to W_WAIT.
- W_WAIT: breadyM=1; on bvalidM, capture brespM and go to W_RESP.
- W_RESP: bvalid=1 with the captured bresp; on bready, go to W_IDLE.

Read FSM: R_IDLE, R_ISSUE, R_WAIT, R_RESP.
- R_IDLE: arready=1; on arvalid, capture araddr/arprot and go to R_ISSUE.
- R_ISSUE: arvalidM=1; on arreadyM, go to R_WAIT.
- R_WAIT: rreadyM=1; on rvalidM, capture rdataM/rrespM and go to R_RESP.
- R_RESP: rvalid=1; on rready, go to R_IDLE.

General rules:
- The write and read FSMs are fully independent and may overlap.
- Valids never drop before their handshake, and payload is stable while valid is high.
- Responses are passed through unchanged: 00 OKAY, 10 SLVERR, 11 DECERR.
- Reset asserted mid-transaction aborts the transaction silently; nothing is replayed.

## Timing
- S handshake at edge N: the matching M valid is high from cycle N+1.
- Minimum write latency, S AW/W to S bvalid: 3 cycles, assuming M ready and bvalidM are high immediately.
- Minimum read latency, AR to rvalid: 3 cycles under the same condition.
- S ready signals are low in every state except IDLE, which is backpressure by construction.
- Back-to-back transactions: a new AW/W/AR is accepted in the cycle after the response handshake.

## Configuration
- AXIL_STRUCT_ADDR_CHECK_EN defined: a captured address outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) is not forwarded.
  - The FSM goes straight to RESP with resp=11 (DECERR).
  - Read data is 0 in that case.
- AXIL_STRUCT_ADDR_CHECK_EN undefined: every address is forwarded.

## Structure
- Package axil_pkg holds:
  - addrWidth and dataWidth.
  - The resp_t enum: OKAY, EXOKAY, SLVERR, DECERR.
  - ADDR_BASE and ADDR_SIZE.
  - The write and read FSM state enums.
- One sub-module, axil_hold_reg: a valid/payload holding register with load and clear, instantiated per channel.

## Test plan
- Reset: drive rst=0 mid-write → all outputs are 0; after release, awready=wready=arready=1.
- Write with AW and W in the same cycle, addr 0x10, data 0xDEADBEEF, strb 0xF:
  - awaddrM=0x10, wdataM=0xDEADBEEF one cycle later.
  - bresp=00 returned.
- W two cycles before AW, with awreadyM delayed 3 cycles → single M issue; bvalid holds until bready.
- Read: araddr 0x20, downstream returns rdataM=0x12345678 with rrespM=10 → rdata=0x12345678, rresp=10, rvalid held until rready.
- Overlapping read and write, with rready held low 5 cycles → both complete correctly; arready stays 0 until the R handshake.
- With AXIL_STRUCT_ADDR_CHECK_EN, read of an out-of-range address → no arvalidM; rresp=11, rdata=0.
